// File: rtl/sample_output_serializer.sv
// sample_output_serializer: FIFO-buffered mono sample to I2S (BCLK/WS/SD) serializer.
// Optional build macro UNDERFLOW_HOLD_EN: an underflow frame repeats the last sample instead of silence.
`default_nettype none

module sample_output_serializer #(
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_SampleReady,
  input  logic [15:0]                   i_Sample,
  input  logic                          i_ClearFlags,
  output logic                          o_BitClock,
  output logic                          o_WordSelect,
  output logic                          o_SerialData,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
  output logic                          o_Overflow,
  output logic                          o_Underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic             primed;
  logic [15:0]      frame;
  logic             prev_lsb;

  logic             div_wrap;
  logic             bclk_fall;
  logic             frame_start;
  logic             fifo_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             underflow_evt;
  logic [4:0]       slot_next;
  logic [3:0]       bit_idx;
  logic [15:0]      frame_next;
  logic             prev_lsb_next;
  logic             sd_next;

  always_comb begin
    div_wrap      = (div_cnt == DIV_LAST);
    bclk_fall     = div_wrap && o_BitClock;
    slot_next     = slot + 5'd1;
    frame_start   = bclk_fall && (slot_next == 5'd0);
    fifo_empty    = (level == '0);
    pop           = frame_start && !fifo_empty;
    underflow_evt = frame_start && fifo_empty && primed;
    // Pop is resolved first, so a full FIFO still accepts a write in a pop cycle.
    push          = i_SampleReady && ((level != LVL_FULL) || pop);
    drop          = i_SampleReady && !push;

    frame_next = frame;
    if (pop) begin
      frame_next = mem[rd_ptr];
    end else if (frame_start) begin
`ifdef UNDERFLOW_HOLD_EN
      frame_next = frame;
`else
      frame_next = '0;
`endif
    end

    prev_lsb_next = frame_start ? frame[0] : prev_lsb;
    // Slots 1..16 carry bits 15..0 and slots 17..31 carry bits 15..1; both are (-slot) mod 16.
    bit_idx = 4'd0 - slot_next[3:0];
    sd_next = (slot_next == 5'd0) ? prev_lsb_next : frame_next[bit_idx];
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Sample;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      div_cnt      <= '0;
      o_BitClock   <= 1'b0;
      o_WordSelect <= 1'b0;
      o_SerialData <= 1'b0;
      o_Overflow   <= 1'b0;
      o_Underflow  <= 1'b0;
      slot         <= 5'd31;
      frame        <= '0;
      prev_lsb     <= 1'b0;
      primed       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
    end else begin
      if (div_wrap) begin
        div_cnt    <= '0;
        o_BitClock <= ~o_BitClock;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (bclk_fall) begin
        slot         <= slot_next;
        o_WordSelect <= slot_next[4];
        o_SerialData <= sd_next;
      end

      if (frame_start) begin
        frame    <= frame_next;
        prev_lsb <= prev_lsb_next;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        primed <= 1'b1;
      end
      level <= level + LVL_W'(push) - LVL_W'(pop);

      // A set event outranks a same-cycle clear.
      o_Overflow  <= drop | (o_Overflow & ~i_ClearFlags);
      o_Underflow <= underflow_evt | (o_Underflow & ~i_ClearFlags);
    end
  end

  assign o_FifoLevel = level;

endmodule

`default_nettype wire

// File: tb/tb_sample_output_serializer.sv
// Bench for sample_output_serializer: I2S decoder plus FIFO reference model and frame scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_sample_output_serializer;

  localparam int FIFO_DEPTH = 8;
  localparam int BCLK_DIV   = 4;
  localparam int FRAME_CYC  = 64 * BCLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] sample = 16'h0000;
  logic        bclk, ws, sd, ovf, unf;
  logic [3:0]  level;

  always #5 clk = ~clk;

  sample_output_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .BCLK_DIV(BCLK_DIV)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_SampleReady(ready),
    .i_Sample     (sample),
    .i_ClearFlags (clear),
    .o_BitClock   (bclk),
    .o_WordSelect (ws),
    .o_SerialData (sd),
    .o_FifoLevel  (level),
    .o_Overflow   (ovf),
    .o_Underflow  (unf)
  );

  typedef struct {
    logic [15:0] sample;
    logic [31:0] stream;
  } vec_t;
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: 32-bit expected SD stream per queued sample.
  logic [31:0] mfifo[$];
  logic [31:0] exp_q[$];
  logic [31:0] drv_stream = 32'h0;
  logic [31:0] shreg = 32'h0;
  logic [31:0] last_frame = 32'h0;
  logic [31:0] cur, frame_bits;
  int          cyc = 0;
  int          c_m = 31;
  int          frames_done = 0;
  bit          have = 0, m_primed = 0, m_ovf = 0, m_unf = 0;
  bit          fall, ovf_set, unf_set;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      cyc = 0; c_m = 31; have = 0; m_primed = 0; m_ovf = 0; m_unf = 0;
      shreg = 0; last_frame = 0;
      mfifo.delete(); exp_q.delete();
      check("in_reset_outputs", {bclk, ws, sd, ovf, unf, level}, 32'h0);
    end else begin
      cyc++;
      check("bclk", 32'(bclk), 32'((cyc / BCLK_DIV) % 2));
      fall = (cyc % (2 * BCLK_DIV)) == 0;
      ovf_set = 0;
      unf_set = 0;
      if (fall) begin
        c_m = (c_m + 1) % 32;
        check("ws", 32'(ws), 32'(c_m >= 16));
        if (c_m == 0) begin
          if (have) begin
            frame_bits = {shreg[30:0], sd};
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL frame: actual %0h required <none queued>", frame_bits);
            end else begin
              check("frame", frame_bits, exp_q.pop_front());
            end
            frames_done++;
          end
          if (mfifo.size() > 0) begin
            cur = mfifo.pop_front();
          end else begin
`ifdef UNDERFLOW_HOLD_EN
            cur = last_frame;
`else
            cur = 32'h0;
`endif
            if (m_primed) unf_set = 1;
          end
          last_frame = cur;
          exp_q.push_back(cur);
          have = 1;
          shreg = 0;
        end else begin
          shreg = {shreg[30:0], sd};
        end
      end
      if (ready) begin
        if (mfifo.size() < FIFO_DEPTH) begin
          mfifo.push_back(drv_stream);
          m_primed = 1;
        end else begin
          ovf_set = 1;
        end
      end
      m_ovf = ovf_set | (m_ovf & !clear);
      m_unf = unf_set | (m_unf & !clear);
      check("level", 32'(level), 32'(mfifo.size()));
      check("overflow", 32'(ovf), 32'(m_ovf));
      check("underflow", 32'(unf), 32'(m_unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] s, input logic [31:0] st);
    tick();
    ready = 1; sample = s; drv_stream = st;
    tick();
    ready = 0;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int budget = (n + 1) * FRAME_CYC;
    while (frames_done < target && budget > 0) begin
      tick();
      budget--;
    end
    if (frames_done < target) begin
      checks++; errors++;
      $display("FAIL wait_frames: actual %0d required %0d (timeout)", frames_done, target);
    end
  endtask

  task automatic wait_slot(input int s);
    int budget = 2 * FRAME_CYC;
    tick();
    while (c_m != s && budget > 0) begin
      tick();
      budget--;
    end
    if (c_m != s) begin
      checks++; errors++;
      $display("FAIL wait_slot: actual %0d required %0d (timeout)", c_m, s);
    end
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 32'hA5C3A5C3};
    vecs[1] = '{16'h8001, 32'h80018001};
    vecs[2] = '{16'h7FFF, 32'h7FFF7FFF};
    vecs[3] = '{16'h0001, 32'h00010001};

    repeat (3) tick();
    check("reset_state", {bclk, ws, sd, ovf, unf, level}, 32'h0);
    rst = 0;

    // Idle stream, unprimed: silence and no underflow.
    wait_frames(4);
    check("unprimed_underflow", 32'(unf), 32'h0);

    for (int i = 0; i < 4; i++) begin
      wait_slot(20);
      push(vecs[i].sample, vecs[i].stream);
      wait_frames(2);
    end
    check("drain_underflow", 32'(unf), 32'h1);
    tick(); clear = 1;
    tick(); clear = 0;
    check("clear_underflow", 32'(unf), 32'h0);

    // Nine back-to-back writes with no pop in between.
    wait_slot(1);
    for (int i = 0; i < 9; i++) begin
      tick();
      ready = 1; sample = 16'h1000 + 16'(i); drv_stream = {sample, sample};
    end
    tick();
    ready = 0;
    check("burst_level", 32'(level), 32'h8);
    check("burst_overflow", 32'(ovf), 32'h1);

    ready = 1; clear = 1; sample = 16'hDEAD; drv_stream = 32'hDEADDEAD;
    tick();
    ready = 0; clear = 0;
    check("clear_vs_overflow", 32'(ovf), 32'h1);
    check("full_write_dropped_level", 32'(level), 32'h8);
    clear = 1;
    tick();
    clear = 0;
    check("clear_overflow", 32'(ovf), 32'h0);
    wait_frames(10);

    // Prime with the most negative value and let it drain.
    tick(); clear = 1;
    tick(); clear = 0;
    wait_slot(20);
    push(16'h8000, 32'h80008000);
    wait_frames(3);
    check("prime_drain_underflow", 32'(unf), 32'h1);

    // Reset mid-frame with three samples queued.
    wait_slot(1);
    push(16'h1111, 32'h11111111);
    push(16'h2222, 32'h22222222);
    push(16'h3333, 32'h33333333);
    check("queued_level", 32'(level), 32'h3);
    wait_slot(9);
    rst = 1;
    #1;
    check("async_reset_outputs", {bclk, ws, sd, ovf, unf}, 32'h0);
    check("async_reset_level", 32'(level), 32'h0);
    tick(); tick();
    rst = 0;
    wait_frames(2);
    check("post_reset_underflow", 32'(unf), 32'h0);
    check("post_reset_level", 32'(level), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
